// File: rtl/vram_pixel_fetch.sv
// vram_pixel_fetch
//   Display-side reader of the dual-port VRAM. For each display line it
//   fetches the matching source line of the linear 1 bpp bitmap
//   (BYTES_PER_LINE bytes per line, LINES lines). It then turns those bytes
//   into a pixel stream, MSB first. Each source pixel is repeated HSCALE
//   clocks across the line, and each source line is repeated over VSCALE
//   display lines.
//
// Ports
//   clk          pixel clock, shared with the VRAM read port
//   nrst         synchronous active-low reset
//   frameStart   one-cycle pulse ahead of the first line of a frame
//   lineStart    one-cycle pulse, at least 3 cycles before the line's pixelEn
//   pixelEn      high during the visible pixels of the line
//   vramRdAddr   13-bit VRAM read address (registered)
//   vramRdData   VRAM read data, valid one cycle after the address
//   pixelOut     registered pixel, 0 whenever pixelValid is 0
//   pixelValid   pixelEn delayed by one cycle
//   underrun     sticky flag: a pixel was needed before its byte arrived

module vram_pixel_fetch #(
    parameter int BYTES_PER_LINE = 40,
    parameter int LINES          = 128,
    parameter int HSCALE         = 2,
    parameter int VSCALE         = 3
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic        frameStart,
    input  logic        lineStart,
    input  logic        pixelEn,
    output logic [12:0] vramRdAddr,
    input  logic [7:0]  vramRdData,
    output logic        pixelOut,
    output logic        pixelValid,
    output logic        underrun
);

    localparam int LIW = $clog2(LINES + 1);
    localparam int RCW = $clog2(VSCALE + 1);
    localparam int HCW = $clog2(HSCALE + 1);
    localparam int BIW = $clog2(BYTES_PER_LINE + 1);

    localparam logic [LIW-1:0] LINES_L  = LIW'(LINES);
    localparam logic [LIW-1:0] LINES_M1 = LIW'(LINES - 1);
    localparam logic [RCW-1:0] VS_M1    = RCW'(VSCALE - 1);
    localparam logic [HCW-1:0] HS_M1    = HCW'(HSCALE - 1);
    localparam logic [BIW-1:0] BPL_B    = BIW'(BYTES_PER_LINE);
    localparam logic [BIW-1:0] BPL_M1   = BIW'(BYTES_PER_LINE - 1);
    localparam logic [12:0]    BPL_A    = 13'(BYTES_PER_LINE);

    typedef enum logic [2:0] {
        IDLE,
        PREFETCH,
        LOAD,
        ACTIVE,
        BLANK
    } FetchState;

    FetchState       state, stateD;
    logic [12:0]     lineBase, lineBaseD;
    logic [12:0]     addrD;
    logic [LIW-1:0]  lineIdx, lineIdxD;
    logic [RCW-1:0]  repCnt, repCntD;
    logic [BIW-1:0]  byteIdx, byteIdxD;
    logic [7:0]      shifter, shifterD;
    logic [3:0]      bitCnt, bitCntD;
    logic [HCW-1:0]  hCnt, hCntD;
    logic [7:0]      nextByte, nextByteD;
    logic            nextValid, nextValidD;
    logic            fetchPending, fetchPendingD;
    logic            pixelOutD;
    logic            underrunD;

    logic            pix;
    logic            setUnderrun;
    logic            empty;
    logic [7:0]      curBits;
    logic [3:0]      curCnt;
    logic            pixelFall;
    logic            advanceLine;

    // Next-state and datapath logic. An empty shifter is refilled from
    // nextByte in the same cycle it is needed, through curBits/curCnt, so
    // there is no bubble between bytes. The refill then schedules the next
    // VRAM capture for the following edge (fetchPending). pixelValid is the
    // registered pixelEn, so it also marks the falling edge of pixelEn.
    always_comb begin
        stateD        = state;
        addrD         = vramRdAddr;
        lineBaseD     = lineBase;
        lineIdxD      = lineIdx;
        repCntD       = repCnt;
        byteIdxD      = byteIdx;
        shifterD      = shifter;
        bitCntD       = bitCnt;
        hCntD         = hCnt;
        nextByteD     = nextByte;
        nextValidD    = nextValid;
        fetchPendingD = fetchPending;
        pix           = 1'b0;
        setUnderrun   = 1'b0;
        advanceLine   = 1'b0;
        empty         = (bitCnt == 4'd0);
        curBits       = empty ? nextByte : shifter;
        curCnt        = empty ? 4'd8 : bitCnt;
        pixelFall     = pixelValid & ~pixelEn;

        case (state)
            IDLE: begin
            end
            PREFETCH: begin
                stateD = LOAD;
                if (pixelEn) begin
                    setUnderrun = 1'b1;
                end
            end
            LOAD: begin
                nextByteD  = vramRdData;
                nextValidD = 1'b1;
                byteIdxD   = BIW'(1);
                if (BYTES_PER_LINE > 1) begin
                    addrD = lineBase + 13'd1;
                end
                stateD = ACTIVE;
                if (pixelEn) begin
                    setUnderrun = 1'b1;
                end
            end
            ACTIVE: begin
                if (fetchPending) begin
                    nextByteD     = vramRdData;
                    nextValidD    = 1'b1;
                    fetchPendingD = 1'b0;
                    byteIdxD      = byteIdx + 1'b1;
                    if (byteIdx < BPL_M1) begin
                        addrD = vramRdAddr + 13'd1;
                    end
                end
                if (pixelEn) begin
                    if (!empty || nextValid) begin
                        pix = curBits[7];
                        if (empty) begin
                            nextValidD = 1'b0;
                            if (byteIdx < BPL_B) begin
                                fetchPendingD = 1'b1;
                            end
                        end
                        if (hCnt == HS_M1) begin
                            hCntD    = '0;
                            shifterD = {curBits[6:0], 1'b0};
                            bitCntD  = curCnt - 4'd1;
                        end else begin
                            hCntD    = hCnt + 1'b1;
                            shifterD = curBits;
                            bitCntD  = curCnt;
                        end
                    end else if (byteIdx != BPL_B || fetchPending) begin
                        setUnderrun = 1'b1;
                    end
                end
                if (pixelFall) begin
                    advanceLine = 1'b1;
                    stateD      = IDLE;
                end
            end
            BLANK: begin
                if (pixelFall) begin
                    advanceLine = 1'b1;
                    stateD      = IDLE;
                end
            end
            default: begin
                stateD = IDLE;
            end
        endcase

        if (advanceLine && !lineStart) begin
            if (repCnt == VS_M1) begin
                repCntD = '0;
                if (lineIdx < LINES_L) begin
                    lineIdxD = lineIdx + 1'b1;
                    if (lineIdx < LINES_M1) begin
                        lineBaseD = lineBase + BPL_A;
                    end
                end
            end else begin
                repCntD = repCnt + 1'b1;
            end
        end

        if (lineStart) begin
            bitCntD       = '0;
            hCntD         = '0;
            nextValidD    = 1'b0;
            fetchPendingD = 1'b0;
            if (lineIdx < LINES_L) begin
                addrD    = lineBase;
                byteIdxD = '0;
                stateD   = PREFETCH;
            end else begin
                stateD = BLANK;
            end
        end

        if (frameStart) begin
            lineBaseD     = '0;
            lineIdxD      = '0;
            repCntD       = '0;
            bitCntD       = '0;
            hCntD         = '0;
            nextValidD    = 1'b0;
            fetchPendingD = 1'b0;
            stateD        = IDLE;
        end

        pixelOutD = pixelEn & pix;
        underrunD = frameStart ? 1'b0 : (underrun | setUnderrun);
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            state        <= IDLE;
            vramRdAddr   <= '0;
            lineBase     <= '0;
            lineIdx      <= '0;
            repCnt       <= '0;
            byteIdx      <= '0;
            shifter      <= '0;
            bitCnt       <= '0;
            hCnt         <= '0;
            nextByte     <= '0;
            nextValid    <= 1'b0;
            fetchPending <= 1'b0;
            pixelOut     <= 1'b0;
            pixelValid   <= 1'b0;
            underrun     <= 1'b0;
        end else begin
            state        <= stateD;
            vramRdAddr   <= addrD;
            lineBase     <= lineBaseD;
            lineIdx      <= lineIdxD;
            repCnt       <= repCntD;
            byteIdx      <= byteIdxD;
            shifter      <= shifterD;
            bitCnt       <= bitCntD;
            hCnt         <= hCntD;
            nextByte     <= nextByteD;
            nextValid    <= nextValidD;
            fetchPending <= fetchPendingD;
            pixelOut     <= pixelOutD;
            pixelValid   <= pixelEn;
            underrun     <= underrunD;
        end
    end

endmodule

// File: tb/tb_vram_pixel_fetch.sv
// tb_vram_pixel_fetch
//   Directed bench for vram_pixel_fetch with its default parameters. A
//   behavioural synchronous VRAM feeds the design. Expected pixels come from
//   a reference model of the scaled bitmap. They are queued when pixelEn is
//   driven, then popped when pixelValid comes back.

module tb_vram_pixel_fetch;

    localparam int BPL   = 40;
    localparam int LINES = 128;
    localparam int HS    = 2;
    localparam int VS    = 3;

    logic        clk = 1'b0;
    logic        nrst;
    logic        frameStart;
    logic        lineStart;
    logic        pixelEn;
    logic [12:0] vramRdAddr;
    logic [7:0]  vramRdData;
    logic        pixelOut;
    logic        pixelValid;
    logic        underrun;

    logic [7:0]  mem [0:8191];
    bit          expQ[$];
    logic [12:0] addrLog[$];
    bit          monEn = 1'b0;
    int          compared = 0;
    int          mismatched = 0;

    // Free-running pixel clock.
    always #5 clk = ~clk;

    // Synchronous VRAM read port: data follows the address by one cycle.
    always @(posedge clk) begin
        vramRdData <= mem[vramRdAddr];
    end

    vram_pixel_fetch #(
        .BYTES_PER_LINE(BPL),
        .LINES(LINES),
        .HSCALE(HS),
        .VSCALE(VS)
    ) dut (
        .clk(clk),
        .nrst(nrst),
        .frameStart(frameStart),
        .lineStart(lineStart),
        .pixelEn(pixelEn),
        .vramRdAddr(vramRdAddr),
        .vramRdData(vramRdData),
        .pixelOut(pixelOut),
        .pixelValid(pixelValid),
        .underrun(underrun)
    );

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic fs, input logic ls, input logic pe, input bit expPix);
        @(negedge clk);
        frameStart = fs;
        lineStart  = ls;
        pixelEn    = pe;
        if (pe && monEn) begin
            expQ.push_back(expPix);
        end
    endtask

    // Reference pixel for a display line and display pixel position.
    function automatic bit expPixel(input int dispLine, input int dispPix);
        int          src;
        int          sp;
        int          b;
        logic [7:0]  byteV;
        if (dispLine >= LINES * VS) return 1'b0;
        src = dispLine / VS;
        sp  = dispPix / HS;
        b   = sp / 8;
        if (b >= BPL) return 1'b0;
        byteV = mem[src * BPL + b];
        return byteV[7 - (sp % 8)];
    endfunction

    task automatic logAddr();
        if (addrLog.size() == 0 || addrLog[addrLog.size() - 1] !== vramRdAddr) begin
            addrLog.push_back(vramRdAddr);
        end
    endtask

    // One display line: lineStart, three quiet cycles, nPix visible pixels,
    // then the falling pixelEn. Optionally checks the distinct addresses seen.
    task automatic runLine(input int dispLine, input int nPix, input bit chkAddr,
                           input int expFirst, input int expCount);
        addrLog.delete();
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
            logAddr();
        end
        for (int i = 0; i < nPix; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b1, expPixel(dispLine, i));
            logAddr();
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        logAddr();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput($sformatf("line%0d queue drained", dispLine), expQ.size(), 0);
        if (chkAddr) begin
            checkOutput($sformatf("line%0d first addr", dispLine), addrLog[0], expFirst);
            checkOutput($sformatf("line%0d addr count", dispLine), addrLog.size(), expCount);
            checkOutput($sformatf("line%0d last addr", dispLine),
                        addrLog[addrLog.size() - 1], expFirst + expCount - 1);
        end
    endtask

    // Scoreboard side: every pixelValid cycle pops one expected pixel, and
    // pixelOut must be 0 whenever pixelValid is low.
    always @(negedge clk) begin
        if (pixelValid && monEn) begin
            if (expQ.size() == 0) begin
                checkOutput("unexpected pixelValid", 32'd1, 32'd0);
            end else begin
                checkOutput("pixel", pixelOut, expQ.pop_front());
            end
        end else if (!pixelValid) begin
            checkOutput("pixelOut idle", pixelOut, 1'b0);
        end
    end

    initial begin
        for (int i = 0; i < 8192; i++) begin
            mem[i] = 8'($urandom);
        end
        mem[0]       = 8'hA5;
        mem[1]       = 8'hFF;
        mem[13'h13FF] = 8'h01;

        nrst       = 1'b0;
        frameStart = 1'b0;
        lineStart  = 1'b0;
        pixelEn    = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("reset addr", vramRdAddr, 13'd0);
        checkOutput("reset pixelOut", pixelOut, 1'b0);
        checkOutput("reset pixelValid", pixelValid, 1'b0);
        checkOutput("reset underrun", underrun, 1'b0);
        nrst  = 1'b1;
        monEn = 1'b1;

        $display("[TB] first line: 0xA5 then 0xFF, 32 pixels");
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        runLine(0, 32, 1'b0, 0, 0);
        checkOutput("line0 addr seq0", addrLog[0], 13'd0);
        checkOutput("line0 addr seq1", addrLog[1], 13'd1);
        checkOutput("line0 addr seq2", addrLog[2], 13'd2);

        $display("[TB] wide lines 1-3, vertical repeat");
        runLine(1, 660, 1'b1, 0, 40);
        runLine(2, 660, 1'b1, 0, 40);
        runLine(3, 660, 1'b1, 40, 40);
        checkOutput("no underrun after full lines", underrun, 1'b0);

        $display("[TB] short lines up to the bottom of the bitmap");
        for (int l = 4; l < 383; l++) begin
            runLine(l, 4, 1'b0, 0, 0);
        end
        runLine(383, 660, 1'b1, 13'h13D8, 40);
        runLine(384, 660, 1'b1, 13'h13FF, 1);
        checkOutput("no underrun at bottom", underrun, 1'b0);

        $display("[TB] early pixelEn underrun");
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b1, (i < 2) ? 1'b0 : expPixel(0, i - 2));
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("underrun set", underrun, 1'b1);
        checkOutput("underrun queue drained", expQ.size(), 0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("underrun cleared", underrun, 1'b0);

        $display("[TB] reset in the middle of a line");
        monEn = 1'b0;
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        end
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        end
        checkOutput("pre-reset addr moved", vramRdAddr, 13'd2);
        nrst = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        nrst = 1'b1;
        checkOutput("midline reset addr", vramRdAddr, 13'd0);
        checkOutput("midline reset pixelOut", pixelOut, 1'b0);
        checkOutput("midline reset pixelValid", pixelValid, 1'b0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
            checkOutput("post-reset pixelValid", pixelValid, 1'b1);
            checkOutput("post-reset pixelOut", pixelOut, 1'b0);
            checkOutput("post-reset addr held", vramRdAddr, 13'd0);
            checkOutput("post-reset underrun", underrun, 1'b0);
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
